surf_cmd_decoder: RTL

//  Consumes the single-ended CMD bit stream produced by the LVDS input buffer in the SURF

---
 rtl/surf_cmd_decoder_pkg.sv | 29 ++
 rtl/surf_sync_ff.sv | 21 ++
 rtl/surf_cmd_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/surf_cmd_decoder_pkg.sv
// Shared definitions for the TURF serial command link: payload layout,
// opcode values, decoder FSM states and the parity rule.
package surf_cmd_decoder_pkg;

    localparam int PAYLOAD_W = 4;

    localparam logic [1:0] OP_TRIG  = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_EVRST = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_RESYNC = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] opcode;
        logic [1:0] buf_sel;
    } payload_t;

    // Odd parity: payload plus parity bit must carry an odd number of ones.
    function automatic logic parity_ok(input payload_t p, input logic par);
        return ^{p, par};
    endfunction

endpackage

// File: rtl/surf_sync_ff.sv
// Multi-flop bit synchronizer; the output is the last stage.
module surf_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/surf_cmd_decoder.sv
// Decoder for TURF serial command frames on the 33 MHz clock:
// start(1), 4 payload bits MSB first, odd parity, stop(0).
module surf_cmd_decoder
    import surf_cmd_decoder_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clk33_i,
    input  logic                    rst_i,
    input  logic                    CMD,
    input  logic                    enable_i,
    input  logic                    cnt_clr_i,
    output logic                    cmd_valid_o,
    output logic [3:0]              cmd_o,
    output logic                    trig_o,
    output logic                    clr_o,
    output logic                    evrst_o,
    output logic [1:0]              buf_o,
    output logic                    err_o,
    output logic [ERR_CNT_BITS-1:0] err_cnt_o
);

    logic     cmd_s;
    state_t   state, state_nxt;
    logic [1:0] bit_cnt;
    payload_t shreg;
    logic     par_ok;
    logic     good, bad;

    surf_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk33_i),
        .rst (rst_i),
        .d   (CMD),
        .q   (cmd_s)
    );

    // FSM state register.
    always_ff @(posedge clk33_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; frame verdict is formed while the stop bit is sampled.
    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        bad       = 1'b0;
        if (!enable_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (cmd_s) state_nxt = ST_DATA;
                ST_DATA:   if (bit_cnt == 2'(PAYLOAD_W - 1)) state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    good      = !cmd_s && par_ok;
                    bad       = cmd_s || !par_ok;
                    state_nxt = cmd_s ? ST_RESYNC : ST_IDLE;
                end
                // A line stuck high is never mistaken for a start bit.
                ST_RESYNC: if (!cmd_s) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Payload bit counter, cleared whenever the FSM leaves DATA.
    always_ff @(posedge clk33_i) begin
        if (rst_i)                bit_cnt <= '0;
        else if (state == ST_DATA) bit_cnt <= bit_cnt + 2'd1;
        else                      bit_cnt <= '0;
    end

    // Payload shift register and parity check latch.
    always_ff @(posedge clk33_i) begin
        if (state == ST_DATA)
            shreg <= payload_t'({shreg[PAYLOAD_W-2:0], cmd_s});
        if (state == ST_PARITY)
            par_ok <= parity_ok(shreg, cmd_s);
    end

    // Registered strobes, held payload fields and saturating error counter.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            cmd_valid_o <= 1'b0;
            trig_o      <= 1'b0;
            clr_o       <= 1'b0;
            evrst_o     <= 1'b0;
            err_o       <= 1'b0;
            cmd_o       <= '0;
            buf_o       <= '0;
            err_cnt_o   <= '0;
        end else begin
            cmd_valid_o <= good;
            trig_o      <= good && (shreg.opcode == OP_TRIG);
            clr_o       <= good && (shreg.opcode == OP_CLR);
            evrst_o     <= good && (shreg.opcode == OP_EVRST);
            err_o       <= bad;
            if (good) begin
                cmd_o <= shreg;
                buf_o <= shreg.buf_sel;
            end
            if (cnt_clr_i)
                err_cnt_o <= '0;
            else if (bad && (err_cnt_o != '1))
                err_cnt_o <= err_cnt_o + ERR_CNT_BITS'(1);
        end
    end

endmodule
